// File: rtl/io_port_pkg.sv
// Shared types for the io port blocks.
// Occupancy state encoding and drop-counter width.
package io_port_pkg;

    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_t;

endpackage

// File: rtl/io_out_port_if.sv
// Consumer-side valid/ready handshake of the output port.
// master drives the word, slave accepts it.
interface io_out_port_if #(
    parameter int BITS = 16
);

    logic            dout_valid;
    logic [BITS-1:0] dout;
    logic            dout_ready;

    modport master (
        output dout_valid,
        output dout,
        input  dout_ready
    );

    modport slave (
        input  dout_valid,
        input  dout,
        output dout_ready
    );

endinterface

// File: rtl/io_out_port_mem.sv
// DEPTH x BITS buffer storage for io_out_port.
// One synchronous write port, one asynchronous read port, no reset.
module io_out_port_mem #(
    parameter int BITS  = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [BITS-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [BITS-1:0]          rdata
);

    logic [BITS-1:0] mem [DEPTH];

    // Store the pushed word; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/io_out_port.sv
// CPU output port: buffers save/in writes and drains them over valid/ready.
// Define IO_OUT_PORT_DROP_CNT_EN to count rejected writes in drop_cnt.
module io_out_port
    import io_port_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  save,
    input  logic [BITS-1:0]       in,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    io_out_port_if.master         dport
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic [BITS-1:0] rdata;
    logic            valid;
    logic            push;
    logic            pop;
    occ_t            state;
    occ_t            state_nxt;

    // Acceptance looks only at this cycle's full, so a same-cycle pop
    // never rescues a write to a full buffer.
    assign push = save & ~full;
    assign pop  = valid & dport.dout_ready;

    io_out_port_mem #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wp),
        .wdata (in),
        .raddr (rp),
        .rdata (rdata)
    );

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy transitions; tracks count so the flags stay registered.
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = PARTIAL;
                end
            end
            PARTIAL: begin
                if (push && !pop && count == CNT_LAST) begin
                    state_nxt = FULL;
                end else if (pop && !push && count == CNT_ONE) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt = PARTIAL;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Status flags decoded from the registered state only.
    always_comb begin
        full  = 1'b0;
        empty = 1'b0;
        valid = 1'b0;
        unique case (state)
            EMPTY:   empty = 1'b1;
            PARTIAL: valid = 1'b1;
            FULL: begin
                full  = 1'b1;
                valid = 1'b1;
            end
            default: empty = 1'b1;
        endcase
    end

    assign dport.dout_valid = valid;
    assign dport.dout       = valid ? rdata : '0;

`ifdef IO_OUT_PORT_DROP_CNT_EN
    logic drop;

    assign drop = save & full;

    // Saturating count of writes rejected because the buffer was full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_io_out_port.sv
// Self-checking bench for io_out_port.
// Scoreboard queue holds accepted words; pops compare against its head.
module tb_io_out_port;

    localparam int BITS  = 16;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst;
    logic            save;
    logic [BITS-1:0] in;
    logic            full;
    logic            empty;
    logic [2:0]      count;
    logic [7:0]      drop_cnt;

    io_out_port_if #(.BITS(BITS)) dif ();

    io_out_port #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .save     (save),
        .in       (in),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .drop_cnt (drop_cnt),
        .dport    (dif)
    );

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    int drop_exp = 0;
    logic [BITS-1:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1, "timeout");
    end

    // One cycle: drive at negedge, score pops, check after next posedge.
    task automatic step(input logic s, input logic [BITS-1:0] d,
                        input logic r);
        bit full_now;
        logic [BITS-1:0] exp;
        save = s;
        in = d;
        dif.dout_ready = r;
        full_now = (sb.size() == DEPTH);
        if (r) begin
            checks++;
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                pops++;
                if (dif.dout !== exp) begin
                    errors++;
                    $display("FAIL pop_data: got %h want %h", dif.dout, exp);
                end
            end else if (dif.dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid: got %b want 0", dif.dout_valid);
            end
        end
        if (s) begin
            if (!full_now) begin
                sb.push_back(d);
            end else begin
`ifdef IO_OUT_PORT_DROP_CNT_EN
                if (drop_exp < 255) drop_exp++;
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (count !== 3'(sb.size())) begin
            errors++;
            $display("FAIL count: got %0d want %0d", count, sb.size());
        end
        checks++;
        if (dif.dout_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL valid: got %b want %b", dif.dout_valid,
                     sb.size() != 0);
        end
        checks++;
        if (full !== (sb.size() == DEPTH)) begin
            errors++;
            $display("FAIL full: got %b want %b", full, sb.size() == DEPTH);
        end
    endtask

    task automatic idle();
        save = 1'b0;
        dif.dout_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        save = 1'b1;
        in = 16'hBEEF;
        dif.dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle();
        sb.delete();
        drop_exp = 0;
    endtask

    task automatic test_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 1'b0);
        do_reset();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL rst_empty: got %b want 1", empty);
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL rst_count: got %0d want 0", count);
        end
        checks++;
        if (dif.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid: got %b want 0", dif.dout_valid);
        end
        checks++;
        if (dif.dout !== 16'h0000) begin
            errors++;
            $display("FAIL rst_dout: got %h want 0000", dif.dout);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_drop: got %0d want 0", drop_cnt);
        end
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL rst_full: got %b want 0", full);
        end
    endtask

    task automatic test_single_write();
        step(1'b1, 16'hFFF0, 1'b0);
        checks++;
        if (dif.dout !== 16'hFFF0) begin
            errors++;
            $display("FAIL single_dout: got %h want fff0", dif.dout);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h1234, 1'b0);
            checks++;
            if (dif.dout !== 16'hFFF0) begin
                errors++;
                $display("FAIL single_hold: got %h want fff0", dif.dout);
            end
        end
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL single_empty: got %b want 1", empty);
        end
        idle();
    endtask

    task automatic test_order_wrap();
        int p0;
        p0 = pops;
        for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0);
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL wrap_full: got %b want 1", full);
        end
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'd5, 1'b0);
        step(1'b1, 16'd6, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
        checks++;
        if (pops - p0 != 6 || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_drain: got pops=%0d empty=%b want 6 1",
                     pops - p0, empty);
        end
        idle();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b1, 16'd32, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
        checks++;
        if (drop_cnt !== 8'(drop_exp)) begin
            errors++;
            $display("FAIL ovf_drop: got %0d want %0d", drop_cnt, drop_exp);
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL ovf_empty: got %b want 1", empty);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 16'hA001, 1'b0);
        step(1'b1, 16'hA002, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'($urandom_range(0, 65535)), 1'b1);
            checks++;
            if (count !== 3'd2) begin
                errors++;
                $display("FAIL b2b_count: got %0d want 2", count);
            end
        end
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 16'(i + 7), 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 16'hDEAD, 1'b0);
        checks++;
        if (drop_cnt !== 8'(drop_exp)) begin
            errors++;
            $display("FAIL sat_drop: got %0d want %0d", drop_cnt, drop_exp);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
        idle();
    endtask

    initial begin
        rst = 1'b0;
        save = 1'b0;
        in = '0;
        dif.dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_single_write();
        test_order_wrap();
        test_overflow();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_out_port.md
# io_out_port

Processor-side output port that buffers values written by the datapath and hands them to an external consumer over a valid/ready handshake. It is the read/drain end of the datapath's save-enabled register writes: the CPU strobes `save` with `in` exactly as it would load a register, and the device side pops words in order. It sits between the core's memory-mapped I/O decode and an off-core peripheral such as a display or UART transmitter.

## Interface
- `BITS`, 16, data word width.
- `DEPTH`, 4, buffer entries; power of two, minimum 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-low: `rst`=0 at a rising `clk` edge resets the block.
- `save`  in  1  CPU write strobe; requests a push of `in`.
- `in`  in  BITS  CPU write data.
- `full`  out  1  buffer holds DEPTH words.
- `empty`  out  1  buffer holds 0 words.
- `count`  out  $clog2(DEPTH)+1  words held, 0..DEPTH.
- `dout_valid`  out  1  `dout` holds the oldest word.
- `dout`  out  BITS  oldest word; 0 when `dout_valid`=0.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `drop_cnt`  out  8  saturating count of rejected writes (see Configuration).

## Operation
- Circular buffer with write pointer `wp`, read pointer `rp`, both $clog2(DEPTH) bits, wrapping modulo DEPTH; `count` tracked explicitly.
- Occupancy state, derived from `count`: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- Push: `save`=1 and `full`=0. Writes `in` to `mem[wp]`; `wp`++.
- Pop: `dout_valid`=1 and `dout_ready`=1. `rp`++.
- `dout_valid` = !`empty`; `dout` = `mem[rp]` when valid, else 0.
- Push and pop in the same cycle: both occur; `count` unchanged.
- `save` while `full`: word dropped even if a pop occurs that cycle (acceptance uses current-cycle `full` only); `drop_cnt` increments.
- `dout_ready` while empty: ignored.
- Transitions: EMPTY→PARTIAL on push; PARTIAL→FULL on push without pop at `count`=DEPTH-1; FULL→PARTIAL on pop; PARTIAL→EMPTY on pop without push at `count`=1.
- `in` with X or any value is stored verbatim; no sign handling.

## Timing
- Reset values: `count`=0, `wp`=`rp`=0, `empty`=1, `full`=0, `dout_valid`=0, `dout`=0, `drop_cnt`=0. Storage array not cleared.
- Reset mid-operation: all buffered words discarded; a `save` or pop in the reset cycle has no effect.
- Write-to-valid latency: 1 cycle (push at edge N, `dout_valid`=1 after edge N).
- `full`, `empty`, `count`, `dout_valid` are registered-state functions; no combinational path from `save` or `dout_ready` to any output.
- `dout` is combinational from `mem[rp]`; stable while `dout_valid`=1 and no pop.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- `IO_OUT_PORT_DROP_CNT_EN` defined: 8-bit `drop_cnt` increments on each rejected `save`, saturates at 255, cleared only by reset.
- Undefined: counter logic omitted; `drop_cnt` tied to 0. All other behaviour identical.

## Structure
- Shared package `io_port_pkg`: occupancy state enum (EMPTY, PARTIAL, FULL) and constant `DROP_CNT_W`=8.
- One sub-module, `io_out_port_mem`: DEPTH x BITS storage with one synchronous write port and one asynchronous read port.
- Top level holds pointers, count, state decode, handshake, and drop counter.

## Test plan
- Reset: `rst`=0 for one cycle after arbitrary traffic -> `empty`=1, `count`=0, `dout_valid`=0, `dout`=0, `drop_cnt`=0.
- Single write: `save`=1, `in`=16'hFFF0 (-16), `dout_ready`=0 -> next cycle `dout_valid`=1, `dout`=16'hFFF0, `count`=1; holds while `dout_ready`=0.
- Order and wrap: push 1,2,3,4 (`full`=1), pop 2, push 5,6, pop 4 -> words out 1,2,3,4,5,6; `empty`=1 at end.
- Overflow: full with 1..4, `save` `in`=32 while `dout_ready`=1 -> 32 not stored, pops yield 1..4, `drop_cnt`=1 (0 without macro).
- Simultaneous push/pop at `count`=2: `save`=1, `dout_ready`=1 for 10 cycles -> `count` stays 2, output order preserved.
- Saturation (macro on): 300 writes while full -> `drop_cnt`=255.
